mvma_stream: RTL
================

# mvma_stream

Parametrised streaming matrix-vector multiply-add engine computing y = W·x + b for a K×K signed matrix. It is the generalised successor to the fixed 3×3 engine: element width, accumulator width, K and overflow mode are parameters. It adds optional matrix/bias reuse across packets and a stable output handshake. It sits between two valid/ready streams: coefficients and vectors in, results out.

## Interface
- K, 3, matrix dimension (K ≥ 2).
- IW, 8, signed input element width.
- OW, 16, signed accumulator/output width (OW ≥ 2·IW).
- SAT, 0, overflow mode: 0 = two's-complement wrap, 1 = saturate.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- s_valid  in  1  input element valid.
- s_ready  out  1  engine accepts input element.
- data_in  in  IW  signed input element.
- keep_w  in  1  reuse stored W and b for the next packet.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- data_out  out  OW  signed result y[i].
- overflow  out  1  y[i] overflowed during accumulation; qualified by m_valid.

## Operation
- Packet input order: W row-major (K·K elements), then b (K elements), then x (K elements). An element transfers on a cycle where s_valid && s_ready.
- Storage: synchronous-read RAMs for W (K·K×IW), b (K×IW) and x (K×IW), with 1-cycle read latency. W and b are never cleared by reset. A w_loaded flag is cleared by reset and set when the last b element is accepted.
- States:
  - LOAD_W: after K·K accepts, go to LOAD_B.
  - LOAD_B: after K accepts, go to LOAD_X.
  - LOAD_X: after K accepts, go to COMPUTE.
  - COMPUTE: row i is evaluated; go to OUTPUT.
  - OUTPUT: on m_valid && m_ready, i+1 → COMPUTE. After row K−1 is accepted, go to LOAD_X if keep_w && w_loaded, otherwise LOAD_W. keep_w is sampled on that accept cycle only.
- s_ready is 1 only in the LOAD_* states and 0 while reset is asserted. Elements offered with s_ready = 0 are not consumed. data_in is ignored when s_valid = 0 (X-tolerant).
- Row arithmetic:
  - The accumulator starts at sign_extend(b[i]) to OW bits.
  - Each of the K products W[i][j]·x[j] is a full-precision 2·IW signed product, sign-extended to OW and added in j order.
- Overflow: flagged on any addition where both operands have the same sign and the OW-bit sum differs in sign.
  - The flag is sticky for the row and cleared at the start of the next row.
  - SAT = 0: the sum wraps.
  - SAT = 1: on the first overflow, the accumulator clamps to +2^(OW−1)−1 (positive operands) or −2^(OW−1) (negative operands). Remaining terms of that row are ignored.
- data_out and overflow are registered. They are held stable while m_valid && !m_ready.

## Timing
- Reset values, asserted asynchronously: m_valid = 0, overflow = 0, data_out = 0, s_ready = 0, state = LOAD_W, row and element counters = 0, w_loaded = 0.
- s_ready rises in the first cycle after reset deasserts.
- Latency: m_valid for row 0 rises exactly K+2 cycles after the handshake of the last x element. For row i>0, m_valid rises exactly K+2 cycles after the accept of row i−1.
- s_ready falls in the cycle after the last x handshake. It rises in the cycle after the last row is accepted.
- m_valid stays high until accepted. It drops in the cycle after the m_valid && m_ready edge.
- Back-to-back: a new packet's first element can be accepted in the cycle after the final result accept.
- Reset mid-packet or mid-output: everything is aborted immediately. Partial data is discarded, and the next packet must be complete even if keep_w = 1.

## Test plan
- Basic, K=3: W=1..9, b=1,2,3, x=1,2,3 → y = 15, 34, 53, overflow 0,0,0. First m_valid comes exactly 5 cycles after the last x handshake.
- Wrap, SAT=0: W=127,127,50,4,5,6,7,8,9, b=15,2,3, x=127,127,10 → y = −32763 (overflow 1), 1205 (0), 1998 (0).
- Saturate, SAT=1: same stimulus → y = 32767 (overflow 1), 1205 (0), 1998 (0).
- Reuse: after the basic packet, keep_w=1 on the last accept, then send x=1,1,1 → exactly 3 handshakes before s_ready drops; y = 7, 17, 27.
- Backpressure, K=4: random s_valid/m_ready gaps over 30 packets. Results must match the reference model, and data_out/overflow must stay stable while m_valid && !m_ready.
- Reset mid-load: pulse reset after 5 W elements. m_valid, overflow and s_ready must be 0 within the reset cycle. keep_w=1 must then be ignored, and a full basic packet → 15, 34, 53.

Source files
------------

// File: rtl/mvma_stream.sv
// Streaming y = W*x + b engine for a KxK signed matrix. Loads W, b and x into sync-read RAMs, then evaluates one row per output beat.
// Row result appears K+2 cycles after the last x accept (or the previous row accept); s_ready low outside the load phases.
module mvma_stream #(
  parameter int K   = 3,
  parameter int IW  = 8,
  parameter int OW  = 16,
  parameter int SAT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [IW-1:0] data_in,
  input  logic          keep_w,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] data_out,
  output logic          overflow
);

  localparam int WAW = $clog2(K*K);
  localparam int XAW = $clog2(K);
  localparam int CW  = $clog2(K*K+2);
  localparam logic signed [OW-1:0] SMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] SMIN = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [2:0] {LOAD_W, LOAD_B, LOAD_X, COMPUTE, OUTPUT} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [XAW-1:0]        row;
  logic                  w_loaded;
  logic signed [OW-1:0]  acc;
  logic                  ovf_acc;

  logic signed [IW-1:0]  w_mem [K*K];
  logic signed [IW-1:0]  b_mem [K];
  logic signed [IW-1:0]  x_mem [K];
  logic signed [IW-1:0]  w_rd, b_rd, x_rd;

  logic                  accept;
  logic [XAW-1:0]        rd_j;
  logic [WAW-1:0]        w_raddr;
  logic                  first;
  logic signed [2*IW-1:0] prod;
  logic signed [OW-1:0]  term, base, sum, acc_next;
  logic                  ovf_base, add_ovf, ovf_next;

  assign accept = s_valid && s_ready;

  always_comb begin
    rd_j    = (cnt < CW'(K)) ? XAW'(cnt) : '0;
    w_raddr = WAW'(row) * WAW'(K) + WAW'(rd_j);
  end

  // RAMs carry no reset: W and b survive reset, only w_loaded says whether they are usable.
  always_ff @(posedge clk) begin
    if (accept && state == LOAD_W) w_mem[WAW'(cnt)] <= data_in;
    if (accept && state == LOAD_B) b_mem[XAW'(cnt)] <= data_in;
    if (accept && state == LOAD_X) x_mem[XAW'(cnt)] <= data_in;
    w_rd <= w_mem[w_raddr];
    b_rd <= b_mem[row];
    x_rd <= x_mem[rd_j];
  end

  // One term per cycle; the first term seeds the accumulator with b[row].
  always_comb begin
    first    = (cnt == CW'(1));
    prod     = (2*IW)'(w_rd) * (2*IW)'(x_rd);
    term     = OW'(prod);
    base     = first ? OW'(b_rd) : acc;
    ovf_base = first ? 1'b0 : ovf_acc;
    sum      = base + term;
    add_ovf  = (base[OW-1] == term[OW-1]) && (sum[OW-1] != base[OW-1]);
    acc_next = sum;
    ovf_next = ovf_base | add_ovf;
    if (SAT != 0) begin
      if (ovf_base) begin
        acc_next = base;
        ovf_next = 1'b1;
      end else if (add_ovf) begin
        acc_next = base[OW-1] ? SMIN : SMAX;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= LOAD_W;
      cnt      <= '0;
      row      <= '0;
      w_loaded <= 1'b0;
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      data_out <= '0;
      overflow <= 1'b0;
      acc      <= '0;
      ovf_acc  <= 1'b0;
    end else begin
      case (state)
        LOAD_W: begin
          s_ready <= 1'b1;
          if (accept) begin
            if (cnt == CW'(K*K-1)) begin
              cnt   <= '0;
              state <= LOAD_B;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            if (cnt == CW'(K-1)) begin
              cnt      <= '0;
              w_loaded <= 1'b1;
              state    <= LOAD_X;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        LOAD_X: begin
          if (accept) begin
            if (cnt == CW'(K-1)) begin
              cnt     <= '0;
              s_ready <= 1'b0;
              state   <= COMPUTE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        COMPUTE: begin
          // cnt 0 issues the first read, 1..K accumulate, K+1 publishes the row.
          if (cnt != '0 && cnt <= CW'(K)) begin
            acc     <= acc_next;
            ovf_acc <= ovf_next;
          end
          if (cnt == CW'(K+1)) begin
            cnt      <= '0;
            data_out <= acc;
            overflow <= ovf_acc;
            m_valid  <= 1'b1;
            state    <= OUTPUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        OUTPUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (row == XAW'(K-1)) begin
              row     <= '0;
              s_ready <= 1'b1;
              state   <= (keep_w && w_loaded) ? LOAD_X : LOAD_W;
            end else begin
              row   <= row + XAW'(1);
              state <= COMPUTE;
            end
          end
        end
        default: state <= LOAD_W;
      endcase
    end
  end

endmodule
